// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states
// and lane widths.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10
    } state_t;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    // The reserved encoding 2'b11 behaves as a word access.
    function automatic logic is_word_size(input logic [1:0] sz);
        return sz[1];
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts/extends load data and merges sub-word
// store data into a memory word. LSU_MISALIGN_TRAP_EN enables misalign detection.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged,
    output logic        misaligned
);

    logic [1:0]  eff_off;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic        sign_bit;

    // Halfwords snap to lane 0/2 and words to lane 0; only matters when not trapping.
    always_comb begin
        eff_off = offset;
        if (size == SZ_HALF)
            eff_off = {offset[1], 1'b0};
        else if (is_word_size(size))
            eff_off = 2'b00;
    end

    assign shamt   = {eff_off, 3'b000};
    assign shifted = mem_word >> shamt;

    always_comb begin
        sign_bit  = 1'b0;
        load_data = mem_word;
        merged    = wdata;
        if (size == SZ_BYTE) begin
            sign_bit  = shifted[BYTE_W-1] & ~is_unsigned;
            load_data = {{(32-BYTE_W){sign_bit}}, shifted[BYTE_W-1:0]};
            merged    = (mem_word & ~(32'h0000_00FF << shamt))
                      | ({{(32-BYTE_W){1'b0}}, wdata[BYTE_W-1:0]} << shamt);
        end else if (size == SZ_HALF) begin
            sign_bit  = shifted[HALF_W-1] & ~is_unsigned;
            load_data = {{(32-HALF_W){sign_bit}}, shifted[HALF_W-1:0]};
            merged    = (mem_word & ~(32'h0000_FFFF << shamt))
                      | ({{(32-HALF_W){1'b0}}, wdata[HALF_W-1:0]} << shamt);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((size == SZ_HALF) && offset[0])
                     || (is_word_size(size) && (offset != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide data memory; sub-word stores are
// read-modify-write. Optional misalign trap via LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 32,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       off_q, off_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      merged_q, merged_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;

    logic [31:0]      load_data;
    logic [31:0]      merged_word;
    logic             misaligned;
    logic             unused_addr_hi;

    // Address bits above the word index wrap the memory and are ignored.
    assign unused_addr_hi = ^req_addr[31:IDX_W+2];

    lsu_lane_align u_align (
        .size        (size_q),
        .offset      (off_q),
        .is_unsigned (uns_q),
        .mem_word    (mem_read_data),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged_word),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            idx_q        <= '0;
            wdata_q      <= '0;
            merged_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            merged_q     <= merged_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next state plus request latch; the response registers pulse for exactly one cycle.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        merged_d     = merged_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    idx_d   = req_addr[IDX_W+1:2];
                    wdata_d = req_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (misaligned) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    state_d      = IDLE;
                end else if (!we_q) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                    state_d      = IDLE;
                end else if (is_word_size(size_q)) begin
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    merged_d = merged_word;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (state_q == IDLE) && !rst;
        mem_write_en   = 1'b0;
        mem_write_data = '0;
        mem_addr       = {{(32-IDX_W){1'b0}}, idx_q};
        case (state_q)
            ACCESS: begin
                if (we_q && is_word_size(size_q) && !misaligned) begin
                    mem_write_en   = 1'b1;
                    mem_write_data = wdata_q;
                end
            end
            WRITE: begin
                mem_write_en   = 1'b1;
                mem_write_data = merged_q;
            end
            default: ;
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit with a 32-word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_write_en;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;

    logic [31:0] mem [32];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    assign mem_read_data = mem[mem_addr[4:0]];
    always @(posedge clk) if (mem_write_en) mem[mem_addr[4:0]] <= mem_write_data;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_mem;
        int          exp_lat;
        int          exp_wr;
        logic        exp_err;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic [31:0] exp_mem,
                                input int exp_lat, input int exp_wr, input logic exp_err);
        vec_t v;
        v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_mem = exp_mem;
        v.exp_lat = exp_lat; v.exp_wr = exp_wr; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, id, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          lat, wr, idx;
        logic        got, wd_ok, err;
        logic [31:0] wa, rdat;
        idx = int'(v.addr[6:2]);
        @(negedge clk);
        chk("ready_idle", id, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_size = v.sz; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after acceptance; they must have no effect.
        req_valid = 1'b0; req_we = ~v.we; req_size = ~v.sz; req_unsigned = ~v.uns;
        req_addr = ~v.addr; req_wdata = ~v.wdata;
        chk("ready_busy", id, {31'b0, req_ready}, 32'd0);
        got = 1'b0; lat = 0; wr = 0; wa = '0; wd_ok = 1'b1; rdat = '0; err = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_write_en) begin wr++; wa = mem_addr; end
            else if (mem_write_data != 32'd0) wd_ok = 1'b0;
            if (resp_valid) begin got = 1'b1; lat = c; rdat = resp_rdata; err = resp_err; end
        end
        chk("latency", id, lat, v.exp_lat);
        chk("write_cycles", id, wr, v.exp_wr);
        if (v.exp_wr > 0) chk("write_addr", id, wa, idx);
        chk("wdata_zero_idle", id, {31'b0, wd_ok}, 32'd1);
        chk("rdata", id, rdat, v.exp_rdata);
        chk("err", id, {31'b0, err}, {31'b0, v.exp_err});
        chk("mem_word", id, mem[idx], v.exp_mem);
    endtask

    logic [31:0] bb_addr [3];
    logic [1:0]  bb_sz   [3];
    logic        bb_uns  [3];
    logic [31:0] bb_exp  [3];

    initial begin
        logic [31:0] w4_final;
        int n_acc, n_resp;
        logic prev_acc;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        tbl[0]  = mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 2, 1, 0);
        tbl[1]  = mk(0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 2, 0, 0);
        tbl[2]  = mk(1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 32'h11223344, 2, 1, 0);
        tbl[3]  = mk(1, 2'b00, 0, 32'h12, 32'hFFFFFFAB, 32'h0, 32'h11AB3344, 3, 1, 0);
        tbl[4]  = mk(1, 2'b10, 0, 32'h10, 32'h80FF7F01, 32'h0, 32'h80FF7F01, 2, 1, 0);
        tbl[5]  = mk(0, 2'b00, 0, 32'h12, 32'h0, 32'hFFFFFFFF, 32'h80FF7F01, 2, 0, 0);
        tbl[6]  = mk(0, 2'b00, 1, 32'h12, 32'h0, 32'h000000FF, 32'h80FF7F01, 2, 0, 0);
        tbl[7]  = mk(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF80FF, 32'h80FF7F01, 2, 0, 0);
        tbl[8]  = mk(0, 2'b01, 1, 32'h10, 32'h0, 32'h00007F01, 32'h80FF7F01, 2, 0, 0);
        tbl[9]  = mk(0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 32'h80FF7F01, 2, 0, 0);
        tbl[10] = mk(1, 2'b01, 0, 32'h12, 32'hCAFEBEEF, 32'h0, 32'hBEEF7F01, 3, 1, 0);
        tbl[11] = mk(0, 2'b11, 1, 32'h10, 32'h0, 32'hBEEF7F01, 32'hBEEF7F01, 2, 0, 0);
        tbl[12] = mk(1, 2'b10, 0, 32'h7C, 32'h01020304, 32'h0, 32'h01020304, 2, 1, 0);
        tbl[13] = mk(0, 2'b10, 0, 32'hFFFFFF7C, 32'h0, 32'h01020304, 32'h01020304, 2, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[14] = mk(1, 2'b10, 0, 32'h13, 32'h55667788, 32'h0, 32'hBEEF7F01, 2, 0, 1);
        tbl[15] = mk(0, 2'b01, 0, 32'h11, 32'h0, 32'h0, 32'hBEEF7F01, 2, 0, 1);
        tbl[16] = mk(1, 2'b01, 0, 32'h13, 32'h0000AAAA, 32'h0, 32'hBEEF7F01, 2, 0, 1);
        w4_final = 32'hBEEF7F01;
`else
        tbl[14] = mk(1, 2'b10, 0, 32'h13, 32'h55667788, 32'h0, 32'h55667788, 2, 1, 0);
        tbl[15] = mk(0, 2'b01, 0, 32'h11, 32'h0, 32'h00007788, 32'h55667788, 2, 0, 0);
        tbl[16] = mk(1, 2'b01, 0, 32'h13, 32'h0000AAAA, 32'h0, 32'hAAAA7788, 3, 1, 0);
        w4_final = 32'hAAAA7788;
`endif
        tbl[17] = mk(0, 2'b10, 0, 32'h10, 32'h0, w4_final, w4_final, 2, 0, 0);

        // Reset state
        #12;
        chk("rst_we", 0, {31'b0, mem_write_en}, 32'd0);
        chk("rst_resp_valid", 0, {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", 0, resp_rdata, 32'd0);
        chk("rst_err", 0, {31'b0, resp_err}, 32'd0);
        chk("rst_addr", 0, mem_addr, 32'd0);
        chk("rst_wdata", 0, mem_write_data, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_ready", 0, {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 18; i++) run_vec(tbl[i], i);

        // Back-to-back loads with req_valid held high
        bb_addr[0] = 32'h10; bb_sz[0] = 2'b10; bb_uns[0] = 1'b0; bb_exp[0] = w4_final;
        bb_addr[1] = 32'h7C; bb_sz[1] = 2'b10; bb_uns[1] = 1'b0; bb_exp[1] = 32'h01020304;
        bb_addr[2] = 32'h7F; bb_sz[2] = 2'b00; bb_uns[2] = 1'b1; bb_exp[2] = 32'h00000001;
        n_acc = 0; n_resp = 0; prev_acc = 1'b0;
        for (int c = 0; c < 20 && n_resp < 3; c++) begin
            @(negedge clk);
            if (prev_acc) chk("bb_busy", n_acc, {31'b0, req_ready}, 32'd0);
            prev_acc = 1'b0;
            if (resp_valid) begin
                chk("bb_rdata", n_resp, resp_rdata, bb_exp[n_resp]);
                if (n_acc < 3) chk("bb_ready_with_resp", n_resp, {31'b0, req_ready}, 32'd1);
                n_resp++;
            end
            if (req_ready && n_acc < 3) begin
                req_valid = 1'b1; req_we = 1'b0; req_size = bb_sz[n_acc];
                req_unsigned = bb_uns[n_acc]; req_addr = bb_addr[n_acc];
                n_acc++; prev_acc = 1'b1;
            end else if (n_acc >= 3) begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("bb_resp_count", 0, n_resp, 32'd3);

        // Reset while in WRITE of a byte RMW
        run_vec(mk(1, 2'b10, 0, 32'h10, 32'h0BADF00D, 32'h0, 32'h0BADF00D, 2, 1, 0), 100);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0000005A;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_access_nowr", 0, {31'b0, mem_write_en}, 32'd0);
        @(posedge clk); #1;
        chk("rmw_write_en", 0, {31'b0, mem_write_en}, 32'd1);
        chk("rmw_write_data", 0, mem_write_data, 32'h0BADF05A);
        rst = 1'b1; #1;
        chk("rst_mid_we", 0, {31'b0, mem_write_en}, 32'd0);
        chk("rst_mid_wdata", 0, mem_write_data, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0; #1;
        chk("rst_mid_mem", 0, mem[4], 32'h0BADF00D);
        chk("rst_mid_ready", 0, {31'b0, req_ready}, 32'd1);
        chk("rst_mid_resp", 0, {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("rst_mid_resp_later", 0, {31'b0, resp_valid}, 32'd0);
        run_vec(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h0BADF00D, 32'h0BADF00D, 2, 0, 0), 101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the datapath and the word-wide data memory, directly upstream of it.
- Accepts byte, halfword and word load/store requests with a valid/ready handshake and drives the memory's word address, write enable and write data.
- Extracts and sign/zero-extends load data.
- The memory has a single word write enable, so sub-word stores are done as read-modify-write sequences.

Parameters:
- MEM_WORDS, 32, number of 32-bit words in the data memory; word index is taken modulo MEM_WORDS.
- IDX_W, $clog2(MEM_WORDS), width of the significant word-index bits.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  access size (package enum)
- req_unsigned  input  1  zero-extend loads when 1
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores
- resp_err  output  1  completion was a rejected access (feature only)
- mem_write_en  output  1  to memory write_en
- mem_addr  output  32  to memory addr: word index, zero-extended
- mem_write_data  output  32  to memory write_data
- mem_read_data  input  32  from memory read_data; combinational in mem_addr

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - State returns to IDLE and any in-flight store is abandoned.
  - mem_write_en = 0; resp_valid = 0; resp_rdata = 0; resp_err = 0; mem_addr = 0; mem_write_data = 0; req_ready = 1 once reset is released.
- Address and lanes:
  - word index = req_addr[IDX_W+1:2]; offset = req_addr[1:0].
  - Little-endian: byte lane k = bits 8k+7:8k.
  - Halfword lanes are at offset 0 or 2.
- FSM states: IDLE, ACCESS, WRITE.
- IDLE:
  - req_ready = 1. On a clock edge with req_valid = 1, the request is latched and the state moves to ACCESS.
  - resp_valid may pulse in this same cycle; a new request is still accepted.
- ACCESS:
  - req_ready = 0; mem_addr = latched word index.
  - Load: the selected lane of mem_read_data is extended into resp_rdata. Next state IDLE, with resp_valid = 1 for one cycle.
  - Word store: mem_write_en = 1 and mem_write_data = wdata. Next state IDLE with resp_valid.
  - Byte/half store: a merged word is formed and registered (mem_read_data with the target lane(s) replaced by wdata[7:0] or wdata[15:0]). Next state WRITE; mem_write_en = 0.
- WRITE:
  - mem_write_en = 1 with the merged word at the same mem_addr. Next state IDLE with resp_valid.
- Latency, counted from the accepting edge N:
  - Load or word store: resp_valid is high in the cycle after edge N+1.
  - Byte/half store: resp_valid is high in the cycle after edge N+2.
  - Throughput is one request per 2 or 3 cycles.
- Sign extension:
  - Byte: bit 7 replicated to 32 bits. Half: bit 15 replicated.
  - req_unsigned = 1 forces zero fill.
  - Word loads ignore req_unsigned.
- Reserved req_size = 2'b11 is treated as word.
- mem_write_en is high only in ACCESS (word store) or WRITE, never in IDLE.
- mem_write_data = 0 when mem_write_en = 0.
- Inputs are sampled only on the accepting edge; later changes have no effect.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with offset[0] = 1, or a word access with offset != 0, is misaligned.
  - A misaligned access is accepted normally but performs no memory write.
  - It completes in the cycle after edge N+1 with resp_valid = 1, resp_err = 1 and resp_rdata = 0.
- Undefined:
  - The low offset bits are silently forced aligned: half uses offset[1]; word uses offset 0.
  - The resp_err port is kept and tied to 0.

Decomposition:
- Package lsu_pkg holds:
  - typedef enum logic[1:0] size_t {SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10}.
  - FSM state enum state_t {IDLE, ACCESS, WRITE}.
  - Lane-width constants BYTE_W = 8 and HALF_W = 16.
- One combinational sub-module, lsu_lane_align, is natural:
  - Inputs: size, offset, unsigned flag, memory word, store data.
  - Outputs: extended load data, merged store word, misaligned flag.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x0000_0010 → mem_write_en for exactly 1 cycle with mem_addr = 4. Load word 0x10 → resp_rdata = 0xDEADBEEF 2 cycles after acceptance.
- Byte store RMW: word 4 = 0x11223344; store byte 0xAB at 0x12 → no write in ACCESS. WRITE cycle writes 0x11AB3344; resp_valid 3 cycles after acceptance.
- Sign extension: word 4 = 0x80FF7F01.
  - Signed byte load at 0x12 → 0xFFFFFFFF.
  - Unsigned byte load at 0x12 → 0x000000FF.
  - Signed half load at 0x12 → 0xFFFF80FF.
  - Unsigned half load at 0x10 → 0x00007F01.
- Back-to-back: hold req_valid high for 3 loads → req_ready low during each ACCESS. Each load is accepted in the IDLE cycle carrying the previous resp_valid, and responses arrive in order.
- Reset mid-RMW: assert rst while in WRITE → mem_write_en drops immediately and the memory word is unchanged. After release, req_ready = 1 and resp_valid = 0.
- Misaligned with LSU_MISALIGN_TRAP_EN: word store at 0x13 → resp_err = 1, no mem_write_en. Without the macro: written at word 4 with offset forced to 0, resp_err = 0.
